// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame-length defaults and counter sizing for the SPI slave front end
package spi_pkg;

    localparam int W_CMD_DEF    = 8;
    localparam int W_DATA_DEF   = 16;
    localparam int SYNC_LEN_DEF = 2;

    // Bit counters hold 0..W plus one saturating overrun value.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop input synchroniser with history flop and edge strobes
module spi_sync_edge #(
    parameter int   SYNC_LEN = 2,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_LEN-1:0] sr;
    logic                hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= {SYNC_LEN{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            sr   <= {sr[SYNC_LEN-2:0], din};
            hist <= sr[SYNC_LEN-1];
        end
    end

    assign lvl  = sr[SYNC_LEN-1];
    assign rise = lvl & ~hist;
    assign fall = ~lvl & hist;

endmodule

// File: rtl/spi_slave_frontend.sv
// rtl/spi_slave_frontend.sv - oversampled SPI slave: command/data frame deserialiser and data-frame serialiser
module spi_slave_frontend
    import spi_pkg::*;
#(
    parameter int W_CMD    = W_CMD_DEF,
    parameter int W_DATA   = W_DATA_DEF,
    parameter int SYNC_LEN = SYNC_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_scl,
    input  logic              spi_sdi,
    input  logic              spi_cs_cmd,
    input  logic              spi_cs_data,
    output logic              spi_sdo,
    input  logic [W_DATA-1:0] tx_data,
    output logic              cmd_valid,
    output logic [W_CMD-1:0]  cmd,
    output logic              data_valid,
    output logic [W_DATA-1:0] data,
    output logic              frame_err
);

    localparam int CW_C = cnt_width(W_CMD);
    localparam int CW_D = cnt_width(W_DATA);
    localparam logic [CW_C-1:0] CMD_FULL  = CW_C'(W_CMD);
    localparam logic [CW_C-1:0] CMD_SAT   = CW_C'(W_CMD + 1);
    localparam logic [CW_D-1:0] DATA_FULL = CW_D'(W_DATA);
    localparam logic [CW_D-1:0] DATA_SAT  = CW_D'(W_DATA + 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic csc_lvl, csc_rise, csc_fall;
    logic csd_lvl, csd_rise, csd_fall;

    spi_sync_edge #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b0)) u_sync_scl (
        .clk(clk), .rst_n(rst_n), .din(spi_scl), .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    spi_sync_edge #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .din(spi_sdi), .lvl(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall));
    spi_sync_edge #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b1)) u_sync_csc (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_cmd), .lvl(csc_lvl), .rise(csc_rise), .fall(csc_fall));
    spi_sync_edge #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b1)) u_sync_csd (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_data), .lvl(csd_lvl), .rise(csd_rise), .fall(csd_fall));

    // Only SCL rises and CS rises drive framing; the remaining strobes are spare.
    logic unused_edges;
    assign unused_edges = &{1'b0, scl_lvl, scl_fall, sdi_rise, sdi_fall, csc_fall, csd_fall};

    logic [W_CMD-1:0]  cmd_sr;
    logic [W_DATA-1:0] data_sr;
    logic [W_DATA-1:0] tx_sr;
    logic [CW_C-1:0]   cmd_cnt;
    logic [CW_D-1:0]   data_cnt;
    logic              cmd_bad, data_bad, both_low_d;

    logic both_low, cmd_open, data_open;
    logic cmd_close, data_close, cmd_good, data_good;

    // A frame poisoned by CS overlap stays dead (no shifting, no further error) until its CS rises.
    assign both_low   = ~csc_lvl & ~csd_lvl;
    assign cmd_open   = ~csc_lvl &  csd_lvl & ~cmd_bad;
    assign data_open  = ~csd_lvl &  csc_lvl & ~data_bad;
    assign cmd_close  = csc_rise & ~cmd_bad;
    assign data_close = csd_rise & ~data_bad;
    assign cmd_good   = cmd_close  & (cmd_cnt  == CMD_FULL);
    assign data_good  = data_close & (data_cnt == DATA_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid  <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            cmd        <= '0;
            data       <= '0;
            cmd_sr     <= '0;
            data_sr    <= '0;
            tx_sr      <= '0;
            cmd_cnt    <= '0;
            data_cnt   <= '0;
            cmd_bad    <= 1'b0;
            data_bad   <= 1'b0;
            both_low_d <= 1'b0;
        end else begin
            both_low_d <= both_low;
            cmd_valid  <= cmd_good;
            data_valid <= data_good;
            frame_err  <= (both_low & ~both_low_d) | (cmd_close & ~cmd_good) | (data_close & ~data_good);

            if (cmd_good)  cmd  <= cmd_sr;
            if (data_good) data <= data_sr;

            if (both_low) begin
                cmd_bad  <= 1'b1;
                data_bad <= 1'b1;
            end else begin
                if (csc_rise) cmd_bad  <= 1'b0;
                if (csd_rise) data_bad <= 1'b0;
            end

            if (both_low || csc_rise) begin
                cmd_cnt <= '0;
                cmd_sr  <= '0;
            end else if (scl_rise && cmd_open) begin
                cmd_sr <= {cmd_sr[W_CMD-2:0], sdi_lvl};
                if (cmd_cnt != CMD_SAT) cmd_cnt <= cmd_cnt + 1'b1;
            end

            if (both_low || csd_rise) begin
                data_cnt <= '0;
                data_sr  <= '0;
            end else if (scl_rise && data_open) begin
                data_sr <= {data_sr[W_DATA-2:0], sdi_lvl};
                if (data_cnt != DATA_SAT) data_cnt <= data_cnt + 1'b1;
            end

            // Idle preload keeps the MSB on the line before the first SCL rise.
            if (csd_lvl) begin
                tx_sr <= tx_data;
            end else if (scl_rise && data_open) begin
                tx_sr <= {tx_sr[W_DATA-2:0], 1'b0};
            end
        end
    end

    assign spi_sdo = tx_sr[W_DATA-1] & data_open;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb/tb_spi_slave_frontend.sv - self-checking bench for spi_slave_frontend
module tb_spi_slave_frontend;

    localparam int SYNC_LEN = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_scl, spi_sdi, spi_cs_cmd, spi_cs_data;
    logic        spi_sdo;
    logic [15:0] tx_data;
    logic        cmd_valid, data_valid, frame_err;
    logic [7:0]  cmd;
    logic [15:0] data;

    spi_slave_frontend #(.W_CMD(8), .W_DATA(16), .SYNC_LEN(SYNC_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .spi_scl(spi_scl), .spi_sdi(spi_sdi),
        .spi_cs_cmd(spi_cs_cmd), .spi_cs_data(spi_cs_data), .spi_sdo(spi_sdo),
        .tx_data(tx_data), .cmd_valid(cmd_valid), .cmd(cmd),
        .data_valid(data_valid), .data(data), .frame_err(frame_err));

    always #10 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cmd_cnt = 0, data_cnt = 0, err_cnt = 0, simul_cnt = 0;

    always @(negedge clk) begin
        if (cmd_valid)  cmd_cnt++;
        if (data_valid) data_cnt++;
        if (frame_err)  err_cnt++;
        if (cmd_valid && data_valid) simul_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        int          which;   // 0 cmd, 1 data, 2 both CS
        int          nbits;
        logic [15:0] word;
        logic [15:0] txw;
        int          ecp;
        int          edp;
        int          eep;
        logic [7:0]  ecmd;
        logic [15:0] edata;
    } vec_t;

    vec_t vecs[6];

    // Mode-0 master: SDI set during SCL low, SDO sampled just before each rise.
    task automatic do_frame(input int which, input int nbits, input logic [15:0] word,
                            input logic [15:0] txw, input int ecp, input int edp, input int eep,
                            input logic [7:0] ecmd, input logic [15:0] edata);
        int c0, d0, r0;
        logic [15:0] rd;
        c0 = cmd_cnt; d0 = data_cnt; r0 = err_cnt; rd = '0;
        tx_data = txw;
        #50;
        if (which != 1) spi_cs_cmd = 1'b0;
        if (which != 0) spi_cs_data = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = word[nbits-1-i];
            #50;
            rd = {rd[14:0], spi_sdo};
            spi_scl = 1'b1;
            #50;
            spi_scl = 1'b0;
        end
        #50;
        spi_cs_cmd  = 1'b1;
        spi_cs_data = 1'b1;
        repeat (SYNC_LEN + 2) @(posedge clk);
        #1;
        chk("cmd_pulses",  cmd_cnt  - c0, ecp);
        chk("data_pulses", data_cnt - d0, edp);
        chk("err_pulses",  err_cnt  - r0, eep);
        chk("cmd_value",  cmd,  ecmd);
        chk("data_value", data, edata);
        if (which == 1 && nbits == 16) chk("sdo_read", rd, txw);
        else if (which != 1)           chk("sdo_idle", rd, 16'h0000);
        #100;
    endtask

    logic [15:0] regs [0:255];
    logic [7:0]  m_cmd;
    logic [15:0] m_data, w, sum, txr;
    int          v0, c0, d0, r0;

    initial begin
        vecs[0] = '{0,  8, 16'h0001, 16'h0000, 1, 0, 0, 8'h01, 16'h0000};
        vecs[1] = '{1, 16, 16'hA5C3, 16'h1234, 0, 1, 0, 8'h01, 16'hA5C3};
        vecs[2] = '{0,  7, 16'h007F, 16'h0000, 0, 0, 1, 8'h01, 16'hA5C3};
        vecs[3] = '{0,  9, 16'h01FF, 16'h0000, 0, 0, 1, 8'h01, 16'hA5C3};
        vecs[4] = '{0,  8, 16'h0080, 16'h0000, 1, 0, 0, 8'h80, 16'hA5C3};
        vecs[5] = '{2,  8, 16'h00AA, 16'hFFFF, 0, 0, 1, 8'h80, 16'hA5C3};

        rst_n = 1'b0; spi_scl = 1'b0; spi_sdi = 1'b0;
        spi_cs_cmd = 1'b1; spi_cs_data = 1'b1; tx_data = 16'hBEEF;
        #25;
        chk("rst_outputs", {cmd_valid, data_valid, frame_err, spi_sdo}, 4'b0000);
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_data", data, 16'h0000);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #3;

        foreach (vecs[i])
            do_frame(vecs[i].which, vecs[i].nbits, vecs[i].word, vecs[i].txw,
                     vecs[i].ecp, vecs[i].edp, vecs[i].eep, vecs[i].ecmd, vecs[i].edata);

        // Reset in the middle of a data frame drops it silently.
        c0 = cmd_cnt; d0 = data_cnt; r0 = err_cnt;
        tx_data = 16'hFFFF;
        #50;
        spi_cs_data = 1'b0;
        for (int i = 0; i < 5; i++) begin
            spi_sdi = 1'b1;
            #50 spi_scl = 1'b1;
            #50 spi_scl = 1'b0;
        end
        #20 rst_n = 1'b0;
        #1;
        chk("midrst_sdo", spi_sdo, 1'b0);
        chk("midrst_cmd", cmd, 8'h00);
        chk("midrst_data", data, 16'h0000);
        spi_cs_data = 1'b1;
        #40 rst_n = 1'b1;
        #200;
        chk("midrst_pulses", (cmd_cnt - c0) + (data_cnt - d0) + (err_cnt - r0), 0);
        do_frame(1, 16, 16'hFFFF, 16'h0F0F, 0, 1, 0, 8'h00, 16'hFFFF);

        // Register-file style traffic: writes to 1..3, then read back their sum.
        m_cmd = 8'h00; m_data = 16'hFFFF;
        for (int k = 0; k < 256; k++) regs[k] = 16'h0000;
        for (int l = 0; l < 10; l++) begin
            v0 = cmd_cnt + data_cnt;
            for (int k = 1; k <= 3; k++) begin
                do_frame(0, 8, 16'(k), 16'h0000, 1, 0, 0, 8'(k), m_data);
                m_cmd = 8'(k);
                w = 16'($urandom);
                txr = 16'($urandom);
                do_frame(1, 16, w, txr, 0, 1, 0, m_cmd, w);
                m_data = w;
                regs[m_cmd] = w;
            end
            sum = regs[1] + regs[2] + regs[3];
            do_frame(0, 8, 16'h0080, 16'h0000, 1, 0, 0, 8'h80, m_data);
            m_cmd = 8'h80;
            w = 16'($urandom);
            do_frame(1, 16, w, sum, 0, 1, 0, m_cmd, w);
            m_data = w;
            chk("loop_valid_pulses", (cmd_cnt + data_cnt) - v0, 8);
        end

        chk("no_simultaneous_valid", simul_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
